freq_gate_counter: RTL



---
 rtl/freq_gate_counter.sv | 70 +++++++
 1 files changed

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts synchronised rising edges of sig_in over back-to-back gate windows of GATE_CYCLES clk cycles
module freq_gate_counter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [OUT_WIDTH-1:0] freq,
  output logic                 freq_valid,
  output logic                 overflow,
  output logic                 update
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  typedef enum logic {IDLE, GATE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic [GW-1:0] gate_cnt;
  logic [OUT_WIDTH-1:0] edge_cnt;
  logic [OUT_WIDTH-1:0] next_cnt;
  logic sat;
  logic rise;
  logic sat_hit;
  always_comb begin
    rise = sync[SYNC_STAGES-1] & ~hist;
    sat_hit = rise & (&edge_cnt);
    next_cnt = (rise & ~(&edge_cnt)) ? edge_cnt + OUT_WIDTH'(1) : edge_cnt;
  end
  // The terminal cycle publishes next_cnt so an edge landing there still belongs to the closing window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= 1'b0;
      state <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat <= 1'b0;
      freq <= '0;
      freq_valid <= 1'b0;
      overflow <= 1'b0;
      update <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      hist <= sync[SYNC_STAGES-1];
      update <= 1'b0;
      if (state == IDLE || !enable) begin
        state <= enable && state == IDLE ? GATE : IDLE;
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat <= 1'b0;
      end else if (gate_cnt == LAST) begin
        freq <= next_cnt;
        overflow <= sat | sat_hit;
        update <= 1'b1;
        freq_valid <= 1'b1;
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= next_cnt;
        sat <= sat | sat_hit;
      end
    end
  end
endmodule
